// File: rtl/header_framer_pkg.sv
// Shared constants and state encoding for the header_framer block.
// Optional build macro HEADER_FRAMER_BSWAP_EN is consumed in header_framer.sv.
package header_framer_pkg;

  localparam int HEADER_BYTES_DEFAULT = 80;
  localparam int COUNT_W              = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/header_framer_edge_detector.sv
// Registered rising-edge detector: rise pulses for one cycle, the cycle after
// the input level is first sampled high.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic hist_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_p0 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      hist_p0 <= level;
      rise    <= level & ~hist_p0;
    end
  end

endmodule

// File: rtl/header_framer.sv
// Assembles HEADER_BYTES UART bytes into one header and holds it for the miner.
// Define HEADER_FRAMER_BSWAP_EN to present each 32-bit word byte-reversed.
module header_framer
  import header_framer_pkg::*;
#(
  parameter int HEADER_BYTES = HEADER_BYTES_DEFAULT,
  parameter int GAP_TIMEOUT  = 500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_ready,
  input  logic                      header_ready,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic [COUNT_W-1:0]        byte_count,
  output logic                      frame_error
);

  localparam int HDR_W = HEADER_BYTES * 8;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  state_t             state, state_nxt;
  logic               strobe;
  logic [HDR_W-1:0]   shift_p0;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               valid_nxt;
  logic               err_nxt;
  logic               shift_en;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .level (rx_ready),
    .rise  (strobe)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      byte_count   <= '0;
      header_valid <= 1'b0;
      frame_error  <= 1'b0;
      shift_p0     <= '0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_nxt;
      byte_count   <= count_nxt;
      header_valid <= valid_nxt;
      frame_error  <= err_nxt;
      if (shift_en) shift_p0 <= {shift_p0[HDR_W-9:0], rx_byte};
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    count_nxt = byte_count;
    valid_nxt = header_valid;
    err_nxt   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe) begin
          shift_en  = 1'b1;
          count_nxt = COUNT_W'(1);
          gap_nxt   = '0;
          state_nxt = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (strobe) begin
          shift_en  = 1'b1;
          count_nxt = byte_count + COUNT_W'(1);
          gap_nxt   = '0;
          if (byte_count == COUNT_W'(HEADER_BYTES - 1)) begin
            state_nxt = ST_HOLD;
            valid_nxt = 1'b1;
          end
        end else if (gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
          // Abandon the partial frame; the shift register keeps its bytes.
          err_nxt   = 1'b1;
          count_nxt = '0;
          gap_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      ST_HOLD: begin
        if (header_ready) begin
          valid_nxt = 1'b0;
          if (strobe) begin
            shift_en  = 1'b1;
            count_nxt = COUNT_W'(1);
            gap_nxt   = '0;
            state_nxt = ST_RECEIVE;
          end else begin
            count_nxt = '0;
            state_nxt = ST_IDLE;
          end
        end else if (strobe) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef HEADER_FRAMER_BSWAP_EN
  // Little-endian words from the host become big-endian; word order is kept.
  for (genvar w = 0; w < HEADER_BYTES / 4; w++) begin : g_word
    for (genvar k = 0; k < 4; k++) begin : g_byte
      assign header_data[32*w + 8*k +: 8] = shift_p0[32*w + 8*(3-k) +: 8];
    end
  end
`else
  assign header_data = shift_p0;
`endif

endmodule

// File: tb/tb_header_framer.sv
// Scoreboard bench for header_framer (HEADER_BYTES=80, GAP_TIMEOUT=50).
module tb_header_framer;

  localparam int HB = 80;
  localparam int HW = HB * 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_ready = 1'b0;
  logic          header_ready = 1'b0;
  logic [HW-1:0] header_data;
  logic          header_valid;
  logic [6:0]    byte_count;
  logic          frame_error;

  int            n_checks = 0;
  int            n_errors = 0;
  int            err_pulses = 0;
  int            base;
  logic          prev_valid = 1'b0;
  logic [HW-1:0] sb_q[$];
  logic [7:0]    frame[HB];
  logic [HW-1:0] snap;

  header_framer #(.HEADER_BYTES(HB), .GAP_TIMEOUT(50)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .header_ready (header_ready),
    .header_data  (header_data),
    .header_valid (header_valid),
    .byte_count   (byte_count),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected header: first byte in the MSBs, optionally word byte-swapped.
  function automatic logic [HW-1:0] expected_hdr();
    logic [HW-1:0] h;
    logic [HW-1:0] o;
    for (int i = 0; i < HB; i++) h[HW-1-8*i -: 8] = frame[i];
    o = h;
`ifdef HEADER_FRAMER_BSWAP_EN
    for (int w = 0; w < HB / 4; w++)
      for (int k = 0; k < 4; k++)
        o[32*w + 8*k +: 8] = h[32*w + 8*(3-k) +: 8];
`endif
    return o;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_byte  = b;
    rx_ready = 1'b1;
    repeat (3) @(negedge clock);
    rx_ready = 1'b0;
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (frame_error) err_pulses++;
    if (header_valid && !prev_valid) begin
      if (sb_q.size() == 0) check("sb_unexpected_hdr", 1, 0);
      else begin
        check("sb_hdr", header_data, sb_q.pop_front());
        check("sb_count", byte_count, HB);
      end
    end
    prev_valid = header_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_data", header_data, 0);
    check("rst_valid", header_valid, 0);
    check("rst_count", byte_count, 0);
    check("rst_err", frame_error, 0);
    @(negedge clock);
    reset = 1'b0;

    // Full frame 0x00..0x4F with exact valid timing on the last byte
    for (int i = 0; i < HB; i++) frame[i] = 8'(i);
    sb_q.push_back(expected_hdr());
    for (int i = 0; i < HB - 1; i++) send_byte(8'(i));
    @(negedge clock);
    rx_byte  = 8'h4F;
    rx_ready = 1'b1;
    @(negedge clock);
    check("t27_valid_early", header_valid, 0);
    check("t27_count_early", byte_count, 79);
    @(negedge clock);
    check("t27_valid", header_valid, 1);
    check("t27_count", byte_count, 80);
`ifndef HEADER_FRAMER_BSWAP_EN
    check("t27_msb", header_data[639:632], 8'h00);
    check("t27_lsb", header_data[7:0], 8'h4F);
`endif
    @(negedge clock);
    rx_ready = 1'b0;
    @(negedge clock);

    // Overrun strobe during HOLD
    snap = header_data;
    base = err_pulses;
    send_byte(8'hEE);
    repeat (2) @(negedge clock);
    check("t30_err_pulse", err_pulses - base, 1);
    check("t30_data", header_data, snap);
    check("t30_valid", header_valid, 1);

    // Hold for 100 cycles, then release
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("t28_hold_data", header_data, snap);
      check("t28_hold_valid", header_valid, 1);
    end
    header_ready = 1'b1;
    @(negedge clock);
    header_ready = 1'b0;
    check("t28_rel_valid", header_valid, 0);
    check("t28_rel_count", byte_count, 0);
    check("t28_sb_empty", sb_q.size(), 0);

    // Gap timeout after 10 bytes
    for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
    check("t29_count10", byte_count, 10);
    snap = header_data;
    base = err_pulses;
    repeat (60) @(negedge clock);
    check("t29_err_once", err_pulses - base, 1);
    check("t29_count0", byte_count, 0);
    check("t29_data_kept", header_data, snap);
    send_byte(8'h5A);
    check("t29_count1", byte_count, 1);

    // Asynchronous reset mid-frame at 40 bytes
    for (int i = 0; i < 39; i++) send_byte(8'h10 + 8'(i));
    check("t31_count40", byte_count, 40);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("t31_rst_data", header_data, 0);
    check("t31_rst_valid", header_valid, 0);
    check("t31_rst_count", byte_count, 0);
    check("t31_rst_err", frame_error, 0);
    @(negedge clock);
    reset = 1'b0;

    frame[0] = 8'h01; frame[1] = 8'h02; frame[2] = 8'h03; frame[3] = 8'h04;
    for (int i = 4; i < HB; i++) frame[i] = 8'($urandom_range(0, 255));
    sb_q.push_back(expected_hdr());
    for (int i = 0; i < HB; i++) send_byte(frame[i]);
    repeat (2) @(negedge clock);
    check("t31_sb_drain", sb_q.size(), 0);
    check("t31_valid", header_valid, 1);
`ifdef HEADER_FRAMER_BSWAP_EN
    check("t32_word0", header_data[639:608], 32'h04030201);
`else
    check("t32_word0_raw", header_data[639:608], 32'h01020304);
`endif

    // Release coinciding with a new strobe starts the next frame
    base = err_pulses;
    @(negedge clock);
    rx_byte  = 8'h77;
    rx_ready = 1'b1;
    @(negedge clock);
    header_ready = 1'b1;
    @(negedge clock);
    header_ready = 1'b0;
    check("t19_valid", header_valid, 0);
    check("t19_count", byte_count, 1);
`ifndef HEADER_FRAMER_BSWAP_EN
    check("t19_lsb", header_data[7:0], 8'h77);
`endif
    @(negedge clock);
    rx_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("t19_no_err", err_pulses - base, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/header_framer.md
HEADER_FRAMER -- requirements
Module: header_framer

Interface
REQ-001 SHALL have parameter HEADER_BYTES, default 80, meaning the number of bytes per block header frame.
REQ-002 SHALL have parameter GAP_TIMEOUT, default 500000, meaning the maximum clock cycles allowed between bytes inside a frame.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_byte, input, 8 bits: the received UART byte.
REQ-006 SHALL have port rx_ready, input, 1 bit: a level signal that is high while rx_byte is valid; a byte is taken on its rising edge only.
REQ-007 SHALL have port header_ready, input, 1 bit: the miner accepts the presented header.
REQ-008 SHALL have port header_data, output, HEADER_BYTES*8 bits: the assembled header, with the first received byte in the MSBs.
REQ-009 SHALL have port header_valid, output, 1 bit: the header is complete and held stable.
REQ-010 SHALL have port byte_count, output, 7 bits: the number of bytes collected in the current frame.
REQ-011 SHALL have port frame_error, output, 1 bit: a one-cycle pulse on gap timeout or overrun.

Function
REQ-012 SHALL implement three states: IDLE, RECEIVE and HOLD.
REQ-013 SHALL define a byte strobe as the registered rising edge of rx_ready; each strobe shifts rx_byte into the LSBs of the shift register one cycle after the edge.
REQ-014 On a strobe in IDLE, SHALL store the byte, set byte_count to 1 and move to RECEIVE.
REQ-015 On a strobe in RECEIVE, SHALL store the byte and increment byte_count.
- When the stored byte is byte HEADER_BYTES, SHALL move to HOLD in the same cycle.
- SHALL assert header_valid in the next cycle.
REQ-016 In RECEIVE, SHALL load the gap counter with 0 on each strobe and increment it on every other cycle.
- When the counter reaches GAP_TIMEOUT-1, SHALL pulse frame_error, clear byte_count and return to IDLE.
- The shift register contents SHALL be left unchanged.
REQ-017 In HOLD, SHALL keep header_valid high and header_data frozen until header_ready is sampled high.
- On that cycle, SHALL move to IDLE, deassert header_valid next cycle and clear byte_count.
REQ-018 A strobe received in HOLD SHALL be dropped and SHALL pulse frame_error (overrun); the held header SHALL be unchanged.
REQ-019 If header_ready and a strobe coincide in HOLD, SHALL release the header and start a new frame with that byte (byte_count becomes 1, state RECEIVE), with no frame_error.
REQ-020 SHALL ignore header_ready outside HOLD.
REQ-021 SHALL size byte_count and the gap counter so they never wrap within the parameter range; HEADER_BYTES SHALL be at most 127.

Reset
REQ-022 Reset SHALL force the following values immediately and asynchronously:
- state IDLE;
- header_data 0, header_valid 0, byte_count 0, frame_error 0;
- gap counter 0 and edge-detect history 0.
REQ-023 Reset mid-frame or in HOLD SHALL discard the partial or held header; after reset deasserts, the first strobe SHALL begin a new frame.

Configuration
REQ-024 With HEADER_FRAMER_BSWAP_EN defined, header_data SHALL present each 32-bit word byte-reversed (little-endian to big-endian) while keeping the word order unchanged.
- Without the macro, header_data SHALL be the raw shift register.
- The swap SHALL be combinational from the frozen register and SHALL add no latency.

Structure
REQ-025 SHALL place HEADER_BYTES_DEFAULT, the state encoding constants and the byte-count width in the shared package header_framer_pkg.
REQ-026 SHALL instantiate exactly one sub-module, edge_detector, for rx_ready rising-edge detection; all other logic SHALL be local.

Verification
REQ-027 SHALL drive 80 strobes with bytes 0x00..0x4F -> header_valid rises one cycle after the last strobe, header_data[639:632]=0x00, header_data[7:0]=0x4F, byte_count=80.
REQ-028 SHALL, with header_valid high, hold header_ready low for 100 cycles then high for 1 cycle -> data stable throughout; next cycle header_valid=0, byte_count=0, state IDLE.
REQ-029 SHALL set GAP_TIMEOUT=50, send 10 bytes, then idle 60 cycles -> frame_error pulses exactly once at gap cycle 49; byte_count=0; the next byte gives byte_count=1.
REQ-030 SHALL send an 81st strobe during HOLD -> frame_error pulses, header_data is unchanged, header_valid stays 1.
REQ-031 SHALL assert reset asynchronously after 40 bytes -> all outputs become 0 within the same cycle; a full 80-byte frame afterwards completes correctly.
REQ-032 SHALL, with HEADER_FRAMER_BSWAP_EN defined, send bytes 01 02 03 04 first -> header_data[639:608]=0x04030201.
